// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store path and the IO writer.
// CPU wins by default; an IO wait counter forces an IO grant after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        r_wait_cnt;
    logic              r_io_prio;
    logic              r_rd_pend;
    logic              r_rd_owner;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_io_rdata;
    logic              w_cpu_gnt;
    logic              w_io_gnt;
    logic              w_cpu_rvalid;
    logic              w_io_rvalid;

    // Grant selection; depends only on requests and the registered priority flag
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_io_gnt  = 1'b0;
        if (!reset) begin
            w_cpu_gnt = 1'b0;
            w_io_gnt  = 1'b0;
        end else if (r_io_prio && io_req) begin
            w_io_gnt = 1'b1;
        end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
        end else if (io_req) begin
            w_io_gnt = 1'b1;
        end else begin
            w_cpu_gnt = 1'b0;
            w_io_gnt  = 1'b0;
        end
    end

    // Memory port mux from the granted requester, zeros when idle
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        case ({w_io_gnt, w_cpu_gnt})
            2'b01: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            2'b10: begin
                mem_we    = io_we;
                mem_addr  = io_addr;
                mem_wdata = io_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = {ADDR_W{1'b0}};
                mem_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign io_gnt    = w_io_gnt;
    assign mem_en    = w_cpu_gnt | w_io_gnt;
    assign cpu_stall = reset & cpu_req & ~w_cpu_gnt;

    // IO wait counter and forced-priority flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
            r_io_prio  <= 1'b0;
        end else if (w_io_gnt) begin
            r_wait_cnt <= 4'd0;
            r_io_prio  <= 1'b0;
        end else if (!io_req) begin
            r_wait_cnt <= 4'd0;
            r_io_prio  <= 1'b0;
        end else begin
            r_wait_cnt <= (r_wait_cnt == MAX_WAIT_C) ? r_wait_cnt : r_wait_cnt + 4'd1;
            r_io_prio  <= r_io_prio | (r_wait_cnt == MAX_WAIT_C);
        end
    end

    // Read-return tracking: remembers which requester owns the data arriving next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else if (mem_en && !mem_we) begin
            r_rd_pend  <= 1'b1;
            r_rd_owner <= w_io_gnt;
        end else begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= r_rd_owner;
        end
    end

    assign w_cpu_rvalid = r_rd_pend & ~r_rd_owner;
    assign w_io_rvalid  = r_rd_pend & r_rd_owner;

    // Hold registers keep the last returned word visible while rvalid is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rdata <= {DATA_W{1'b0}};
            r_io_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_cpu_rdata <= w_cpu_rvalid ? mem_rdata : r_cpu_rdata;
            r_io_rdata  <= w_io_rvalid  ? mem_rdata : r_io_rdata;
        end
    end

    assign cpu_rvalid = w_cpu_rvalid;
    assign io_rvalid  = w_io_rvalid;
    assign cpu_rdata  = w_cpu_rvalid ? mem_rdata : r_cpu_rdata;
    assign io_rdata   = w_io_rvalid  ? mem_rdata : r_io_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path (ALU address, register write data) and the keyboard/IO writer that deposits kbin words into memory.
- Sits between the CPU datapath and dmem.
- Issues at most one memory access per cycle and returns read data one cycle later, tagged to the requester that issued it.
- CPU has default priority. A wait counter guarantees the IO requester a grant after MAX_WAIT lost cycles. cpu_stall tells the PC/regfile to hold.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory port.
- DATA_W, 64, data width.
- MAX_WAIT, 4, consecutive cycles io_req may be denied before IO is forced priority (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  DATA_W  CPU load data
- io_req  in  1  IO access request, held until granted
- io_we  in  1  1 = write, 0 = read
- io_addr  in  ADDR_W  IO word address
- io_wdata  in  DATA_W  IO write data
- io_gnt  out  1  IO access issued this cycle
- io_rvalid  out  1  IO read data valid
- io_rdata  out  DATA_W  IO read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

Behaviour:
- Reset (reset=0, asynchronous):
  - wait_cnt=0, io_prio=0, rd_pend=0, rd_owner=0.
  - cpu_rvalid=io_rvalid=0; cpu_rdata=io_rdata=0.
  - Grant outputs forced to 0 while reset is low.
  - An in-flight read is dropped and no rvalid follows deassertion.
- Grant (combinational from req, io_prio):
  - io_prio=1 and io_req: IO granted.
  - Otherwise, cpu_req: CPU granted.
  - Otherwise, io_req: IO granted.
  - Otherwise: no grant.
  - Exactly zero or one gnt per cycle.
- Memory port:
  - mem_en=cpu_gnt|io_gnt.
  - mem_we/addr/wdata muxed from the granted requester.
  - With no grant, mem_we=0 and addr/wdata=0.
- Wait counter and priority (sampled at posedge):
  - io_req & ~io_gnt: wait_cnt increments, saturating at MAX_WAIT.
  - io_gnt: wait_cnt=0 and io_prio=0.
  - ~io_req: wait_cnt=0.
  - io_prio=1 is set when wait_cnt reaches MAX_WAIT (registered, so it is effective the next cycle).
  - Result: the IO worst-case latency under constant CPU traffic is MAX_WAIT+1 cycles from io_req rise to io_gnt.
- Read return:
  - At posedge with mem_en & ~mem_we: rd_pend=1 and rd_owner=granted requester; otherwise rd_pend=0.
  - The cycle after the grant:
    - If rd_owner=CPU: cpu_rvalid=rd_pend and cpu_rdata=mem_rdata.
    - If rd_owner=IO: io_rvalid=rd_pend and io_rdata=mem_rdata.
  - rdata holds its last value when rvalid=0.
  - Back-to-back reads from alternating owners each return in order, one per cycle.
- Writes complete at the grant edge and produce no rvalid.
- Simultaneous cases:
  - Both req with io_prio=0: CPU wins and IO's wait_cnt increments.
  - Both req with io_prio=1: IO wins, CPU stalls one cycle.
- Requesters must hold req/we/addr/wdata stable until gnt. Dropping req early is legal: the request is simply not served and the counter clears.
- No combinational path from mem_rdata to any gnt.

Test Plan:
- Reset mid-read: CPU load at addr 0x10 granted, reset low in the next cycle before posedge → cpu_rvalid stays 0 after release; all outputs 0 during reset.
- Single CPU load: memory[0x20]=0xDEAD, cpu_req=1, cpu_we=0, addr=0x20 → cpu_gnt=1 and mem_en=1 in cycle 0; cpu_rvalid=1 with cpu_rdata=0xDEAD in cycle 1; io_rvalid=0.
- IO starvation, MAX_WAIT=4: cpu_req held 1 continuously with io_req=1 from cycle 0 → io_gnt=1 exactly in cycle 5, cpu_stall=1 in cycle 5 only, CPU granted again in cycle 6.
- Simultaneous first request: cpu_req and io_req rise together, io_we=1, io_addr=1, io_wdata=0x41 → CPU granted in cycle 0; IO write lands in memory[1] once granted; a later CPU load of addr 1 returns 0x41.
- Alternating reads: CPU reads 0x30 (=5) in cycle 0, IO reads 0x31 (=7) in cycle 1 → cpu_rvalid/cpu_rdata=5 in cycle 1, io_rvalid/io_rdata=7 in cycle 2, never both rvalid in the same cycle.
- Idle: no requests → mem_en=0 and mem_we=0; wait_cnt stays 0; a store with cpu_we=1 generates no rvalid.
